// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared state, phase and op encodings for the SRAM march BIST
package sram_bist_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} bist_state_e;
  typedef enum logic [1:0] {P1, P2, P3} bist_phase_e;
  typedef enum logic {RD, WR} bist_op_e;
endpackage

// File: rtl/bist_watchdog.sv
// bist_watchdog: counts stalled cycles and flags the TIMEOUT-th consecutive one
module bist_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + W'(1);
  end
  assign expire_o = en_i && (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl: three-phase march BIST initiator for a req/gnt/rvalid SRAM port
module sram_bist_ctrl import sram_bist_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS = 1024,
  parameter int TIMEOUT = 255,
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [DATA_WIDTH-1:0]   pattern_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    fail_o,
  output logic                    parity_err_o,
  output logic                    timeout_o,
  output logic [ADDR_WIDTH-1:0]   err_addr_o,
  output logic [DATA_WIDTH-1:0]   err_data_o,
  output logic                    req_o,
  output logic                    we_o,
  output logic                    rready_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic                    rvalid_i,
  input  logic                    rvalidpar_i,
  input  logic                    gnt_i,
  input  logic                    gntpar_i
);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  bist_state_e state_q;
  bist_phase_e phase_q, phase_d;
  bist_op_e op_q, op_d;
  logic [AW-1:0] addr_q, addr_d, err_addr_q;
  logic [DW-1:0] pat_q, wdata_q, err_data_q, exp_data;
  logic [DW/8-1:0] be_q;
  logic busy_q, done_q, pass_q, fail_q, par_q, to_q, req_q, we_q, rready_q;
  logic last, fin_d, active, par_hit, to_hit, rd_fail, fin, go_done, wd_en, wd_exp;
  bist_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(!wd_en), .en_i(wd_en), .expire_o(wd_exp)
  );
  always_comb begin
    last = (phase_q == P3) ? (addr_q == '0) : (addr_q == AW'(NUM_WORDS - 1));
    exp_data = (phase_q == P3) ? ~pat_q : pat_q;
    active = (state_q == REQ) || (state_q == RESP);
    wd_en = (state_q == REQ && !gnt_i) || (state_q == RESP && !rvalid_i);
    par_hit = active && ((gntpar_i == gnt_i) || (rvalidpar_i == rvalid_i));
    to_hit = wd_exp;
    rd_fail = state_q == RESP && rvalid_i && op_q == RD && rdata_i != exp_data;
    phase_d = phase_q;
    op_d = op_q;
    addr_d = addr_q;
    fin_d = 1'b0;
    if (phase_q == P2 && op_q == RD) op_d = WR;
    else if (phase_q == P3) begin
      fin_d = last;
      addr_d = addr_q - AW'(1);
    end else if (!last) begin
      op_d = (phase_q == P2) ? RD : WR;
      addr_d = addr_q + AW'(1);
    end else if (phase_q == P1) begin
      phase_d = P2;
      op_d = RD;
      addr_d = '0;
    end else begin
      phase_d = P3;
      op_d = RD;
      addr_d = AW'(NUM_WORDS - 1);
    end
    fin = state_q == RESP && rvalid_i && fin_d;
    go_done = par_hit || to_hit || rd_fail || fin;
  end
  // Every exit to DONE (success or any abort) is funnelled through go_done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      phase_q <= P1;
      op_q <= WR;
      addr_q <= '0;
      pat_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
      {busy_q, done_q, pass_q, fail_q, par_q, to_q, req_q, we_q, rready_q} <= '0;
    end else if (go_done) begin
      state_q <= DONE;
      {done_q, req_q, we_q, rready_q} <= 4'b1000;
      par_q <= par_hit;
      to_q <= to_hit && !par_hit;
      fail_q <= par_hit || to_hit || rd_fail;
      pass_q <= !(par_hit || to_hit || rd_fail);
      if (rd_fail) begin
        err_addr_q <= addr_q;
        err_data_q <= rdata_i;
      end
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= REQ;
          phase_q <= P1;
          op_q <= WR;
          addr_q <= '0;
          pat_q <= pattern_i;
          wdata_q <= pattern_i;
          be_q <= '1;
          err_addr_q <= '0;
          err_data_q <= '0;
          {busy_q, pass_q, fail_q, par_q, to_q, req_q, we_q} <= 7'b1000011;
        end
        REQ: if (gnt_i) begin
          state_q <= RESP;
          req_q <= 1'b0;
          rready_q <= 1'b1;
        end
        RESP: if (rvalid_i) begin
          state_q <= REQ;
          phase_q <= phase_d;
          op_q <= op_d;
          addr_q <= addr_d;
          req_q <= 1'b1;
          rready_q <= 1'b0;
          we_q <= op_d == WR;
          wdata_q <= (phase_d == P1) ? pat_q : ~pat_q;
        end
        default: begin
          state_q <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          be_q <= '0;
        end
      endcase
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pass_o = pass_q;
  assign fail_o = fail_q;
  assign parity_err_o = par_q;
  assign timeout_o = to_q;
  assign err_addr_o = err_addr_q;
  assign err_data_o = err_data_q;
  assign req_o = req_q;
  assign we_o = we_q;
  assign rready_o = rready_q;
  assign addr_o = addr_q;
  assign wdata_o = wdata_q;
  assign be_o = be_q;
endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb_sram_bist_ctrl: directed scenarios against a behavioural SRAM responder
module tb_sram_bist_ctrl;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic [31:0] pattern_i = '0;
  logic busy_o, done_o, pass_o, fail_o, parity_err_o, timeout_o;
  logic [1:0] err_addr_o, addr_o;
  logic [31:0] err_data_o, wdata_o, rdata_i;
  logic req_o, we_o, rready_o;
  logic [3:0] be_o;
  logic rvalid_i, rvalidpar_i, gnt_i, gntpar_i;
  logic gnt_en = 1'b1;
  logic par_glitch = 1'b0;
  logic [1:0] fault = 2'd0;
  logic rvalid_q = 1'b0;
  logic [31:0] rdata_q = '0;
  logic [31:0] mem [4];
  int grants = 0;
  int tests = 0;
  int fails = 0;
  logic [80:0] all_o;

  sram_bist_ctrl #(.DATA_WIDTH(32), .NUM_WORDS(4), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pattern_i(pattern_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
    .parity_err_o(parity_err_o), .timeout_o(timeout_o),
    .err_addr_o(err_addr_o), .err_data_o(err_data_o),
    .req_o(req_o), .we_o(we_o), .rready_o(rready_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .be_o(be_o), .rdata_i(rdata_i),
    .rvalid_i(rvalid_i), .rvalidpar_i(rvalidpar_i), .gnt_i(gnt_i), .gntpar_i(gntpar_i)
  );

  always #5 clk = ~clk;

  assign all_o = {busy_o, done_o, pass_o, fail_o, parity_err_o, timeout_o, err_addr_o,
                  err_data_o, req_o, we_o, rready_o, addr_o, wdata_o, be_o};
  assign gnt_i = gnt_en;
  assign gntpar_i = par_glitch ? gnt_i : ~gnt_i;
  assign rvalid_i = rvalid_q;
  assign rvalidpar_i = ~rvalid_q;
  assign rdata_i = rdata_q;

  // fault 1: word 2 bit 0 stuck-at-1, fault 2: stuck-at-0
  function automatic logic [31:0] flt(input logic [1:0] a, input logic [31:0] d);
    if (a == 2'd2 && fault == 2'd1) return d | 32'h1;
    if (a == 2'd2 && fault == 2'd2) return d & ~32'h1;
    return d;
  endfunction

  always @(posedge clk) begin
    rvalid_q <= 1'b0;
    if (req_o && gnt_i) begin
      grants <= grants + 1;
      rvalid_q <= 1'b1;
      if (we_o) mem[addr_o] <= flt(addr_o, wdata_o);
      rdata_q <= flt(addr_o, mem[addr_o]);
    end
  end

  task automatic launch(input logic [31:0] p);
    @(negedge clk);
    pattern_i = p;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, input int pulse_at, output int done_cyc, output int first_req);
    done_cyc = 0;
    first_req = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      start_i = (c == pulse_at);
      if (req_o && first_req == 0) first_req = c;
      if (done_o) begin
        done_cyc = c;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++; if (all_o !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", all_o); end
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (all_o !== '0) begin fails++; $display("FAIL idle_outputs: got %h want 0", all_o); end
  endtask

  task automatic test_march_pass;
    int dc, fr;
    launch(32'hA5A5_A5A5);
    wait_done(100, 0, dc, fr);
    tests++; if (fr !== 1) begin fails++; $display("FAIL pass_first_req: got %0d want 1", fr); end
    tests++; if (dc !== 33) begin fails++; $display("FAIL pass_done_cycle: got %0d want 33", dc); end
    tests++; if ({busy_o, pass_o, fail_o} !== 3'b110) begin fails++; $display("FAIL pass_flags: got %b want 110", {busy_o, pass_o, fail_o}); end
    @(negedge clk);
    tests++; if ({done_o, busy_o, pass_o} !== 3'b001) begin fails++; $display("FAIL pass_after_done: got %b want 001", {done_o, busy_o, pass_o}); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem[i] !== 32'h5A5A_5A5A) begin fails++; $display("FAIL pass_mem[%0d]: got %h want 5a5a5a5a", i, mem[i]); end
    end
  endtask

  task automatic test_stuck_at_1;
    int dc, fr;
    fault = 2'd1;
    launch(32'hA5A5_A5A5);
    wait_done(100, 0, dc, fr);
    tests++; if (dc !== 29) begin fails++; $display("FAIL sa1_done_cycle: got %0d want 29", dc); end
    tests++; if ({pass_o, fail_o, parity_err_o, timeout_o} !== 4'b0100) begin fails++; $display("FAIL sa1_flags: got %b want 0100", {pass_o, fail_o, parity_err_o, timeout_o}); end
    tests++; if (err_addr_o !== 2'd2) begin fails++; $display("FAIL sa1_err_addr: got %0d want 2", err_addr_o); end
    tests++; if (err_data_o !== 32'h5A5A_5A5B) begin fails++; $display("FAIL sa1_err_data: got %h want 5a5a5a5b", err_data_o); end
    fault = 2'd0;
  endtask

  task automatic test_stuck_at_0;
    int dc, fr;
    fault = 2'd2;
    launch(32'hA5A5_A5A5);
    wait_done(100, 0, dc, fr);
    tests++; if (dc !== 19) begin fails++; $display("FAIL sa0_done_cycle: got %0d want 19", dc); end
    tests++; if ({pass_o, fail_o} !== 2'b01) begin fails++; $display("FAIL sa0_flags: got %b want 01", {pass_o, fail_o}); end
    tests++; if (err_addr_o !== 2'd2) begin fails++; $display("FAIL sa0_err_addr: got %0d want 2", err_addr_o); end
    tests++; if (err_data_o !== 32'hA5A5_A5A4) begin fails++; $display("FAIL sa0_err_data: got %h want a5a5a5a4", err_data_o); end
    fault = 2'd0;
  endtask

  task automatic test_parity;
    launch(32'h1234_5678);
    repeat (4) @(negedge clk);
    @(negedge clk);
    par_glitch = 1'b1;
    @(negedge clk);
    par_glitch = 1'b0;
    tests++; if ({done_o, req_o} !== 2'b10) begin fails++; $display("FAIL par_done_req: got %b want 10", {done_o, req_o}); end
    tests++; if ({parity_err_o, fail_o, timeout_o, pass_o} !== 4'b1100) begin fails++; $display("FAIL par_flags: got %b want 1100", {parity_err_o, fail_o, timeout_o, pass_o}); end
    tests++; if (err_addr_o !== 2'd0) begin fails++; $display("FAIL par_err_addr_cleared: got %0d want 0", err_addr_o); end
    @(negedge clk);
    tests++; if ({done_o, busy_o} !== 2'b00) begin fails++; $display("FAIL par_after_done: got %b want 00", {done_o, busy_o}); end
  endtask

  task automatic test_timeout;
    int dc, fr, g0;
    g0 = grants;
    gnt_en = 1'b0;
    launch(32'hFFFF_0000);
    wait_done(60, 0, dc, fr);
    tests++; if (fr !== 1) begin fails++; $display("FAIL to_first_req: got %0d want 1", fr); end
    tests++; if (dc !== 17) begin fails++; $display("FAIL to_done_cycle: got %0d want 17", dc); end
    tests++; if ({timeout_o, fail_o, parity_err_o, req_o} !== 4'b1100) begin fails++; $display("FAIL to_flags: got %b want 1100", {timeout_o, fail_o, parity_err_o, req_o}); end
    tests++; if (grants !== g0) begin fails++; $display("FAIL to_no_grant: got %0d want %0d", grants, g0); end
    gnt_en = 1'b1;
  endtask

  task automatic test_reset_mid_and_restart;
    int dc, fr;
    launch(32'hA5A5_A5A5);
    repeat (12) @(negedge clk);
    rst_i = 1'b1;
    #1;
    tests++; if (all_o !== '0) begin fails++; $display("FAIL midrst_outputs: got %h want 0", all_o); end
    @(negedge clk);
    tests++; if (all_o !== '0) begin fails++; $display("FAIL midrst_held: got %h want 0", all_o); end
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if ({req_o, busy_o} !== 2'b00) begin fails++; $display("FAIL midrst_no_req: got %b want 00", {req_o, busy_o}); end
    launch(32'h0);
    pattern_i = 32'hDEAD_BEEF;
    wait_done(100, 10, dc, fr);
    tests++; if (dc !== 33) begin fails++; $display("FAIL restart_done_cycle: got %0d want 33", dc); end
    tests++; if ({pass_o, fail_o} !== 2'b10) begin fails++; $display("FAIL restart_flags: got %b want 10", {pass_o, fail_o}); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem[i] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL restart_mem[%0d]: got %h want ffffffff", i, mem[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_march_pass;
    test_stuck_at_1;
    test_stuck_at_0;
    test_parity;
    test_timeout;
    test_reset_mid_and_restart;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
